ppi_commutator_ctrl: RTL and testbench
======================================

// Module: ppi_commutator_ctrl
// PURPOSE
//  Sequencer/commutator for the polyphase interpolator MAC array (mul_add).
//  - Accepts input samples on a valid/ready handshake.
//  - Presents each sample to the array and pulses its enable once per sample.
//  - Captures the parallel L-phase result frame.
//  - Serialises the frame one phase per output handshake: one input sample
//    yields L output samples.
//  - Sits between the sample source and the downstream rate-L stream.
// PARAMETERS
//  gp_idata_width           8   input sample width (matches array i_data)
//  gp_interpolation_factor  32  L, number of phases per frame; must be >= 2
//  gp_phase_width           26  width of one phase slice of array o_data
//  gp_ccw                   0   0: phase 0 = LSB slice; 1: phase 0 = MSB slice
//  (localparam) c_frame_w = gp_phase_width*L; c_ph_w = clog2(L)
// PORTS
//  i_clk        in   1               rising-edge clock
//  i_rst        in   1               synchronous, active-high reset
//  i_flush      in   1               sync abort: drop pending sample and frame
//  i_in_valid   in   1               input sample valid
//  o_in_ready   out  1               input sample ready
//  i_in_data    in   gp_idata_width  input sample, signed
//  o_dp_data    out  gp_idata_width  to array i_data; driven from r_sample
//  o_dp_ena     out  1               to array i_ena; 1-cycle pulse per sample
//  i_dp_data    in   c_frame_w       from array o_data (comb. of o_dp_data)
//  o_out_valid  out  1               output phase valid
//  i_out_ready  in   1               output phase ready
//  o_out_data   out  gp_phase_width  current phase sample, signed
//  o_out_phase  out  c_ph_w          index of current phase, 0..L-1
//  o_out_last   out  1               high with phase L-1
// BEHAVIOUR
//  - Reset: all outputs 0; r_sample_vld=0; state S_IDLE; phase counter 0.
//    Cycle after reset release: o_in_ready=1.
//  - Input side:
//    - o_in_ready = !r_sample_vld.
//    - On in handshake: r_sample <= i_in_data, r_sample_vld <= 1.
//    - o_dp_data = r_sample at all times.
//  - Load event (combinational):
//    load = r_sample_vld & (S_IDLE | (out handshake & phase==L-1)) & !i_flush.
//    - o_dp_ena = load.
//    - On load: r_frame <= i_dp_data (pre-edge array output for r_sample);
//      r_sample_vld <= 0; phase <= 0; state <= S_SERIAL.
//    - Latency: accept at edge k -> o_dp_ena high in cycle k+1 ->
//      o_out_valid from cycle k+2.
//  - FSM:
//    - S_IDLE: o_out_valid=0. Leave on load.
//    - S_SERIAL: o_out_valid=1. Each out handshake increments phase.
//    - At phase L-1 with handshake: load if r_sample_vld (stay S_SERIAL,
//      no bubble); otherwise go to S_IDLE.
//  - Phase slice:
//    - gp_ccw=0: o_out_data = r_frame[(p+1)*W-1 -: W].
//    - gp_ccw=1: o_out_data = slice L-1-p.
//    - o_out_data, o_out_phase and o_out_last stay stable while
//      o_out_valid & !i_out_ready.
//  - Throughput: with i_out_ready=1 and a constant source, 1 sample per L
//    cycles; o_out_valid stays high continuously.
//  - i_flush (priority below i_rst, above everything else):
//    - Next cycle: S_IDLE, r_sample_vld=0, phase=0, no o_dp_ena in the flush
//      cycle.
//    - An in handshake in the flush cycle is discarded.
//  - Reset mid-frame: frame discarded. The array's own registers are not
//    cleared by this block; o_dp_ena stays 0 while i_rst is high.
//  - Widths: no arithmetic here; the slice is passed through unchanged.
// STRUCTURE
//  - Package ppi_pkg: clog2 function, state enum {S_IDLE,S_SERIAL},
//    c_frame_w derivation shared with the array.
//  - One sub-module, ppi_phase_mux: registered frame plus phase index ->
//    slice, honouring gp_ccw.
//  - FSM, counter and input holding register live in the top level.
// TESTING (bench params L=4, W=8, idata=8; array stubbed by a driven i_dp_data)
//  1. i_rst=1 for 3 cycles -> all outputs 0; first cycle after release:
//     o_in_ready=1, o_out_valid=0.
//  2. One sample 0x05, i_dp_data=0x44332211, i_out_ready=1 -> o_dp_data=0x05;
//     o_dp_ena single pulse; outputs 11,22,33,44 with phases 0..3;
//     o_out_last only on 44; then S_IDLE.
//  3. i_in_valid held 1, i_out_ready=1 -> exactly one o_dp_ena per 4 cycles;
//     o_out_valid never drops; 16 phases out for 4 samples.
//  4. i_out_ready pattern 1,0,1,0 -> each phase held 2 cycles unchanged;
//     o_in_ready=0 while a second sample is pending.
//  5. i_flush at phase 2 with a sample pending -> next cycle o_out_valid=0,
//     o_in_ready=1, no o_dp_ena, pending sample never loaded.
//  6. gp_ccw=1, i_dp_data=0x44332211 -> outputs 44,33,22,11; o_out_last on 11.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared definitions for the polyphase interpolator commutator and its MAC array:
// sequencer states, frame width derivation and a constant-safe clog2.
package ppi_pkg;

    typedef enum logic {
        S_IDLE,
        S_SERIAL
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int frame_width(input int phase_w, input int l);
        return phase_w * l;
    endfunction

endpackage

// File: rtl/ppi_phase_mux.sv
// Selects one phase slice out of the captured L-phase frame; gp_ccw reverses
// the slice order so phase 0 comes from the MSB end.
module ppi_phase_mux
    import ppi_pkg::*;
#(
    parameter int gp_interpolation_factor = 32,
    parameter int gp_phase_width          = 26,
    parameter int gp_ccw                  = 0,
    localparam int c_frame_w = frame_width(gp_phase_width, gp_interpolation_factor),
    localparam int c_ph_w    = clog2(gp_interpolation_factor)
)(
    input  logic [c_frame_w-1:0]      frame,
    input  logic [c_ph_w-1:0]         phase,
    output logic [gp_phase_width-1:0] slice
);

    localparam logic [c_ph_w-1:0] c_last_phase = c_ph_w'(gp_interpolation_factor - 1);

    logic [c_ph_w-1:0] sel;

    always_comb begin
        sel   = (gp_ccw != 0) ? (c_last_phase - phase) : phase;
        slice = frame[int'(sel)*gp_phase_width +: gp_phase_width];
    end

endmodule

// File: rtl/ppi_commutator_ctrl.sv
// Sequencer between the sample source, the polyphase MAC array and the rate-L
// output stream: one accepted sample becomes one array strobe and L output phases.
module ppi_commutator_ctrl
    import ppi_pkg::*;
#(
    parameter int gp_idata_width          = 8,
    parameter int gp_interpolation_factor = 32,
    parameter int gp_phase_width          = 26,
    parameter int gp_ccw                  = 0,
    localparam int c_frame_w = frame_width(gp_phase_width, gp_interpolation_factor),
    localparam int c_ph_w    = clog2(gp_interpolation_factor)
)(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_flush,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [gp_idata_width-1:0] i_in_data,
    output logic [gp_idata_width-1:0] o_dp_data,
    output logic                      o_dp_ena,
    input  logic [c_frame_w-1:0]      i_dp_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [gp_phase_width-1:0] o_out_data,
    output logic [c_ph_w-1:0]         o_out_phase,
    output logic                      o_out_last
);

    localparam logic [c_ph_w-1:0] c_last_phase = c_ph_w'(gp_interpolation_factor - 1);

    state_t                    state;
    logic [gp_idata_width-1:0] r_sample;
    logic                      r_sample_vld;
    logic [c_frame_w-1:0]      r_frame;
    logic [c_ph_w-1:0]         r_phase;

    logic at_last;
    logic in_hs;
    logic out_hs;
    logic load;

    assign o_out_valid = (state == S_SERIAL);
    assign at_last     = (r_phase == c_last_phase);
    assign out_hs      = o_out_valid & i_out_ready;
    assign o_in_ready  = ~r_sample_vld & ~i_rst;
    assign in_hs       = i_in_valid & o_in_ready;

    // A new frame is fetched when idle, or back-to-back as the last phase leaves,
    // so a steady source keeps the output stream free of bubbles.
    assign load = r_sample_vld & ((state == S_IDLE) | (out_hs & at_last)) & ~i_flush & ~i_rst;

    assign o_dp_ena    = load;
    assign o_dp_data   = r_sample;
    assign o_out_phase = r_phase;
    assign o_out_last  = o_out_valid & at_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
            r_frame      <= '0;
            r_phase      <= '0;
        end else if (i_flush) begin
            state        <= S_IDLE;
            r_sample_vld <= 1'b0;
            r_phase      <= '0;
        end else begin
            if (in_hs) begin
                r_sample     <= i_in_data;
                r_sample_vld <= 1'b1;
            end
            if (load) begin
                r_frame      <= i_dp_data;
                r_sample_vld <= 1'b0;
                r_phase      <= '0;
                state        <= S_SERIAL;
            end else if (out_hs) begin
                if (at_last) begin
                    state   <= S_IDLE;
                    r_phase <= '0;
                end else begin
                    r_phase <= r_phase + c_ph_w'(1);
                end
            end
        end
    end

    ppi_phase_mux #(
        .gp_interpolation_factor(gp_interpolation_factor),
        .gp_phase_width         (gp_phase_width),
        .gp_ccw                 (gp_ccw)
    ) u_phase_mux (
        .frame(r_frame),
        .phase(r_phase),
        .slice(o_out_data)
    );

endmodule

// File: tb/tb_ppi_commutator_ctrl.sv
// Bench for ppi_commutator_ctrl: a clockwise and a counter-clockwise instance
// share stimulus and are checked every cycle against a frame-queue model.
module tb_ppi_commutator_ctrl;

    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic        in_ready0, in_ready1, dp_ena0, dp_ena1, out_valid0, out_valid1, last0, last1;
    logic [7:0]  dp_data0, dp_data1, out_data0, out_data1;
    logic [1:0]  phase0, phase1;
    logic [31:0] dp_in0, dp_in1;

    // Stand-in for the MAC array: a fixed combinational map from sample to frame.
    function automatic logic [31:0] stub(input logic [7:0] s);
        if (s == 8'h05) return 32'h44332211;
        return {s ^ 8'hA0, s ^ 8'hB0, s ^ 8'hC0, s ^ 8'hD0};
    endfunction

    assign dp_in0 = stub(dp_data0);
    assign dp_in1 = stub(dp_data1);

    ppi_commutator_ctrl #(
        .gp_idata_width(8), .gp_interpolation_factor(L), .gp_phase_width(8), .gp_ccw(0)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready0), .i_in_data(in_data), .o_dp_data(dp_data0),
        .o_dp_ena(dp_ena0), .i_dp_data(dp_in0), .o_out_valid(out_valid0),
        .i_out_ready(out_ready), .o_out_data(out_data0), .o_out_phase(phase0),
        .o_out_last(last0)
    );

    ppi_commutator_ctrl #(
        .gp_idata_width(8), .gp_interpolation_factor(L), .gp_phase_width(8), .gp_ccw(1)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
        .o_in_ready(in_ready1), .i_in_data(in_data), .o_dp_data(dp_data1),
        .o_dp_ena(dp_ena1), .i_dp_data(dp_in1), .o_out_valid(out_valid1),
        .i_out_ready(out_ready), .o_out_data(out_data1), .o_out_phase(phase1),
        .o_out_last(last1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] frame;
        int          ph;
    } beat_t;

    beat_t      q[$];
    bit         m_pend = 1'b0;
    logic [7:0] m_sample = 8'h00;
    bit         model_on = 1'b0;

    function automatic bit exp_ena();
        return !rst && m_pend && !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
    endfunction

    int         beats = 0, enas = 0, accepts = 0, gaps = 0, hold_err = 0, cyc = 0;
    bit         gap_mon = 1'b0, gap_seen = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [1:0] prev_phase = 2'd0;
    logic       prev_last = 1'b0;
    logic [7:0] log0[$], log1[$];
    bit         logl[$];
    int         ena_cyc[$];

    // Compare against the model, record activity, then advance the model with
    // the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        logic [31:0] f;
        bit          ld, hs_in;
        cyc++;
        if (model_on) begin
            check("in_ready", in_ready0, !rst && !m_pend);
            check("in_ready_ccw", in_ready1, !rst && !m_pend);
            check("dp_ena", dp_ena0, exp_ena());
            check("dp_ena_ccw", dp_ena1, exp_ena());
            check("dp_data", dp_data0, m_sample);
            check("dp_data_ccw", dp_data1, m_sample);
            check("out_valid", out_valid0, q.size() > 0);
            check("out_valid_ccw", out_valid1, q.size() > 0);
            if (q.size() > 0) begin
                f = q[0].frame;
                check("out_data", out_data0, f[q[0].ph*8 +: 8]);
                check("out_data_ccw", out_data1, f[(L-1-q[0].ph)*8 +: 8]);
                check("out_phase", phase0, q[0].ph);
                check("out_phase_ccw", phase1, q[0].ph);
                check("out_last", last0, q[0].ph == L-1);
                check("out_last_ccw", last1, q[0].ph == L-1);
            end
        end

        if (prev_stall && (!out_valid0 || out_data0 != prev_data || phase0 != prev_phase || last0 != prev_last))
            hold_err++;
        prev_stall = out_valid0 && !out_ready;
        prev_data  = out_data0;
        prev_phase = phase0;
        prev_last  = last0;

        if (gap_mon) begin
            if (out_valid0) gap_seen = 1'b1;
            else if (gap_seen && beats < 16) gaps++;
        end
        if (out_valid0 && out_ready) begin
            log0.push_back(out_data0);
            log1.push_back(out_data1);
            logl.push_back(last0);
            beats++;
        end
        if (dp_ena0) begin
            enas++;
            ena_cyc.push_back(cyc);
        end
        if (in_valid && in_ready0) accepts++;

        if (rst) begin
            q.delete();
            m_pend   = 1'b0;
            m_sample = 8'h00;
        end else if (flush) begin
            q.delete();
            m_pend = 1'b0;
        end else begin
            ld    = exp_ena();
            hs_in = in_valid && !m_pend;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (ld) begin
                for (int p = 0; p < L; p++) q.push_back('{stub(m_sample), p});
                m_pend = 1'b0;
            end
            if (hs_in) begin
                m_sample = in_data;
                m_pend   = 1'b1;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counters();
        beats = 0; enas = 0; accepts = 0; gaps = 0; hold_err = 0;
        log0.delete(); log1.delete(); logl.delete(); ena_cyc.delete();
    endtask

    initial begin
        int ena_base;
        bit second_seen;

        // Reset held for three cycles
        step(3);
        model_on = 1'b1;
        check("rst_in_ready", in_ready0, 0);
        check("rst_out_valid", out_valid0, 0);
        check("rst_dp_ena", dp_ena0, 0);
        check("rst_dp_data", dp_data0, 0);
        check("rst_out_data", out_data0, 0);
        check("rst_out_phase", phase0, 0);
        check("rst_out_last", last0, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready0, 1);
        check("post_rst_out_valid", out_valid0, 0);

        // Single sample through both slice orders
        clear_counters();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h05;
        step();
        in_valid = 1'b0;
        check("t2_dp_data", dp_data0, 8'h05);
        check("t2_dp_ena", dp_ena0, 1);
        check("t2_valid_early", out_valid0, 0);
        step();
        check("t2_valid", out_valid0, 1);
        check("t2_first", out_data0, 8'h11);
        check("t2_ena_gone", dp_ena0, 0);
        for (int i = 0; i < 20 && beats < 4; i++) step();
        check("t2_beats", beats, 4);
        check("t2_enas", enas, 1);
        check("t2_idle", out_valid0, 0);
        if (log0.size() >= 4) begin
            check("t2_cw0", log0[0], 8'h11);
            check("t2_cw1", log0[1], 8'h22);
            check("t2_cw2", log0[2], 8'h33);
            check("t2_cw3", log0[3], 8'h44);
            check("t2_ccw0", log1[0], 8'h44);
            check("t2_ccw1", log1[1], 8'h33);
            check("t2_ccw2", log1[2], 8'h22);
            check("t2_ccw3", log1[3], 8'h11);
            check("t2_last", {logl[0], logl[1], logl[2], logl[3]}, 4'b0001);
        end

        // Continuous source, continuous sink
        step(2);
        clear_counters();
        gap_mon  = 1'b1;
        gap_seen = 1'b0;
        in_data  = 8'h07;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (accepts >= 4) in_valid = 1'b0;
            if (accepts >= 4 && beats >= 16) break;
        end
        gap_mon = 1'b0;
        check("t3_beats", beats, 16);
        check("t3_enas", enas, 4);
        check("t3_gaps", gaps, 0);
        for (int i = 1; i < ena_cyc.size(); i++)
            check("t3_ena_spacing", ena_cyc[i] - ena_cyc[i-1], 4);

        // Alternating sink readiness with a second sample pending
        step(2);
        clear_counters();
        second_seen = 1'b0;
        in_data  = 8'h21;
        in_valid = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            out_ready = ~out_ready;
            if (accepts >= 2) in_valid = 1'b0;
            if (accepts >= 2 && !second_seen) begin
                second_seen = 1'b1;
                check("t4_pending_ready", in_ready0, 0);
            end
            if (accepts >= 2 && beats >= 8) break;
        end
        check("t4_beats", beats, 8);
        check("t4_enas", enas, 2);
        check("t4_hold", hold_err, 0);

        // Flush at phase 2 while a sample waits
        out_ready = 1'b1;
        step(3);
        clear_counters();
        in_data  = 8'h30;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (accepts >= 1) in_data = 8'h31;
            if (accepts >= 2) in_valid = 1'b0;
            if (accepts >= 2 && out_valid0 && phase0 == 2) break;
        end
        check("t5_phase", phase0, 2);
        check("t5_pending", in_ready0, 0);
        ena_base = enas;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_valid", out_valid0, 0);
        check("t5_ready", in_ready0, 1);
        check("t5_no_ena", enas, ena_base);
        step(4);
        check("t5_no_load", enas, ena_base);
        check("t5_still_idle", out_valid0, 0);

        // Handshake in a flush cycle is discarded
        in_data  = 8'h99;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t5b_ready", in_ready0, 1);
        check("t5b_sample", dp_data0, 8'h31);
        step(3);
        check("t5b_idle", out_valid0, 0);

        // Reset while a sample is about to be loaded
        in_data  = 8'h05;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t7_ena_before", dp_ena0, 1);
        rst = 1'b1;
        #1;
        check("t7_ena_in_rst", dp_ena0, 0);
        check("t7_ready_in_rst", in_ready0, 0);
        step(2);
        rst = 1'b0;
        ena_base = enas;
        #1;
        check("t7_valid", out_valid0, 0);
        check("t7_dp_data", dp_data0, 0);
        check("t7_ready", in_ready0, 1);
        step(3);
        check("t7_no_ena", enas, ena_base);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
